// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_pkg
//  Description : Shared types and default sizing for the HUB75 receive path.
//  Revision    : 1.0  initial release
// ============================================================================
package hub75_pkg;

    localparam int DEF_PIXEL_COLUMNS = 64;
    localparam int DEF_ADDR_BITS     = 4;

    // One pixel lane, bit order {B,G,R}
    typedef logic [2:0] rgb_t;

    // Output drain sequencing: upper half line, then lower half line
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TOP  = 2'd1,
        BOT  = 2'd2
    } drain_state_t;

endpackage : hub75_pkg
`default_nettype wire

// File: rtl/hub75_rx_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx_sync
//  Description : Multi-flop synchronizer with a rising-edge detect register.
//                All bits share the same depth so buses stay cycle-aligned.
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_rx_sync #(
    parameter int               STAGES  = 2,
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_rise
);

    logic [WIDTH-1:0] r_sync [STAGES];
    logic [WIDTH-1:0] r_prev;

    // Synchronizer chain plus one extra flop holding the previous synced value
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_sync[i] <= RST_VAL;
            end
            r_prev <= RST_VAL;
        end else begin
            r_sync[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_q    = r_sync[STAGES-1];
    assign o_rise = o_q & ~r_prev;

endmodule : hub75_rx_sync
`default_nettype wire

// File: rtl/hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : hub75_rx
//  Description : HUB75 receive-side capture. Shifts each incoming line into a
//                capture buffer, commits it on latch into an output buffer and
//                drains it as a valid/ready pixel stream (upper then lower half).
//  Revision    : 1.0  initial release
// ============================================================================
module hub75_rx
    import hub75_pkg::*;
#(
    parameter int PIXEL_COLUMNS = DEF_PIXEL_COLUMNS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             hub_clk,
    input  logic                             hub_lat,
    input  logic                             hub_oe_n,
    input  logic [ADDR_BITS-1:0]             hub_addr,
    input  logic [2:0]                       hub_rgb0,
    input  logic [2:0]                       hub_rgb1,
    output logic                             pix_valid,
    input  logic                             pix_ready,
    output logic [ADDR_BITS:0]               pix_row,
    output logic [$clog2(PIXEL_COLUMNS)-1:0] pix_col,
    output rgb_t                             pix_rgb,
    output logic                             line_done,
    output logic                             oe_active,
    output logic                             len_err,
    output logic                             ovf_err
);

    localparam int c_col_w = $clog2(PIXEL_COLUMNS);
    localparam int c_cnt_w = $clog2(PIXEL_COLUMNS + 1);
    localparam int c_dat_w = ADDR_BITS + 6;
    localparam logic [c_col_w-1:0] c_last_col = c_col_w'(PIXEL_COLUMNS - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(PIXEL_COLUMNS);

    // ---------------- input synchronization ----------------
    logic [2:0]         w_ctl_q, w_ctl_rise;
    logic [c_dat_w-1:0] w_dat_q, w_dat_rise;

    hub75_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(3), .RST_VAL(3'b100)) u_sync_ctl (
        .clk    (clk),
        .rst    (rst),
        .i_d    ({hub_oe_n, hub_lat, hub_clk}),
        .o_q    (w_ctl_q),
        .o_rise (w_ctl_rise)
    );

    hub75_rx_sync #(.STAGES(SYNC_STAGES), .WIDTH(c_dat_w), .RST_VAL('0)) u_sync_dat (
        .clk    (clk),
        .rst    (rst),
        .i_d    ({hub_addr, hub_rgb1, hub_rgb0}),
        .o_q    (w_dat_q),
        .o_rise (w_dat_rise)
    );

    logic                 w_clk_rise, w_lat_rise;
    logic [ADDR_BITS-1:0] w_addr;
    logic [5:0]           w_pix;
    logic                 w_unused;

    assign w_clk_rise = w_ctl_rise[0];
    assign w_lat_rise = w_ctl_rise[1];
    assign oe_active  = ~w_ctl_q[2];
    assign w_addr     = w_dat_q[c_dat_w-1:6];
    assign w_pix      = w_dat_q[5:0];
    assign w_unused   = &{1'b0, w_ctl_rise[2], w_ctl_q[1:0], w_dat_rise};

    // ---------------- capture side ----------------
    logic [5:0]           r_cap [PIXEL_COLUMNS];
    logic [5:0]           r_out [PIXEL_COLUMNS];
    logic [c_cnt_w-1:0]   r_shift_cnt;
    logic                 r_overrun;
    logic                 r_commit;
    logic [ADDR_BITS-1:0] r_lat_addr;
    logic [ADDR_BITS-1:0] r_out_addr;
    drain_state_t         r_state, w_state_nxt;
    logic [c_col_w-1:0]   r_col, w_col_nxt;

    logic                 w_cnt_full, w_len_ok, w_busy;
    logic [c_col_w-1:0]   w_wr_col;

    assign w_cnt_full = (r_shift_cnt == c_full_cnt);
    assign w_wr_col   = c_last_col - r_shift_cnt[c_col_w-1:0];
    // A clock edge in the latch cycle counts toward the line being latched
    assign w_len_ok   = !r_overrun && (w_clk_rise ? (r_shift_cnt == c_full_cnt - c_cnt_w'(1))
                                                  : w_cnt_full);
    assign w_busy     = (r_state != IDLE) || r_commit;

    // Shift counter, overrun tracking, latch decision and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift_cnt <= '0;
            r_overrun   <= 1'b0;
            r_commit    <= 1'b0;
            r_lat_addr  <= '0;
            r_out_addr  <= '0;
            len_err     <= 1'b0;
            ovf_err     <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (r_commit) begin
                r_out_addr <= r_lat_addr;
            end
            if (w_clk_rise) begin
                if (w_cnt_full) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_shift_cnt <= r_shift_cnt + c_cnt_w'(1);
                end
            end
            if (w_lat_rise) begin
                r_shift_cnt <= '0;
                r_overrun   <= 1'b0;
                if (!w_len_ok) begin
                    len_err <= 1'b1;
                end else if (w_busy) begin
                    ovf_err <= 1'b1;
                end else begin
                    r_commit   <= 1'b1;
                    r_lat_addr <= w_addr;
                end
            end
        end
    end

    // Pixel storage: capture on shift edges, snapshot into output buffer on commit.
    // Commit happens one cycle after the latch so a coincident shift sample is included.
    always_ff @(posedge clk) begin
        if (w_clk_rise && !w_cnt_full) begin
            r_cap[w_wr_col] <= w_pix;
        end
        if (r_commit) begin
            r_out <= r_cap;
        end
    end

    // ---------------- drain FSM ----------------
    // State and column registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_col   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
        end
    end

    logic w_fire;
    assign w_fire = pix_valid && pix_ready;

    // Next-state, column advance and end-of-line pulse
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        line_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_commit) begin
                    w_state_nxt = TOP;
                    w_col_nxt   = '0;
                end
            end
            TOP: begin
                if (w_fire) begin
                    if (r_col == c_last_col) begin
                        w_state_nxt = BOT;
                        w_col_nxt   = '0;
                    end else begin
                        w_col_nxt = r_col + c_col_w'(1);
                    end
                end
            end
            BOT: begin
                if (w_fire) begin
                    if (r_col == c_last_col) begin
                        w_state_nxt = IDLE;
                        w_col_nxt   = '0;
                        line_done   = 1'b1;
                    end else begin
                        w_col_nxt = r_col + c_col_w'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_col_nxt   = '0;
            end
        endcase
    end

    // Output word decode, purely from registered state so it is stable under stall
    always_comb begin
        pix_valid = 1'b0;
        pix_row   = '0;
        pix_col   = r_col;
        pix_rgb   = '0;
        case (r_state)
            TOP: begin
                pix_valid = 1'b1;
                pix_row   = {1'b0, r_out_addr};
                pix_rgb   = r_out[r_col][2:0];
            end
            BOT: begin
                pix_valid = 1'b1;
                pix_row   = {1'b1, r_out_addr};
                pix_rgb   = r_out[r_col][5:3];
            end
            default: begin
                pix_col = '0;
            end
        endcase
    end

endmodule : hub75_rx
`default_nettype wire

// File: tb/tb_hub75_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hub75_rx
//  Description : Self-checking bench for hub75_rx with a pixel scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hub75_rx;

    localparam int  c_cols     = 64;
    localparam int  c_half     = 4;
    localparam logic [31:0] c_none = 32'hDEAD_BEEF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hub_clk = 1'b0, hub_lat = 1'b0, hub_oe_n = 1'b0;
    logic [3:0] hub_addr = '0;
    logic [2:0] hub_rgb0 = '0, hub_rgb1 = '0;
    logic       pix_valid, pix_ready = 1'b0;
    logic [4:0] pix_row;
    logic [5:0] pix_col;
    logic [2:0] pix_rgb;
    logic       line_done, oe_active, len_err, ovf_err;

    hub75_rx dut (
        .clk(clk), .rst(rst), .hub_clk(hub_clk), .hub_lat(hub_lat), .hub_oe_n(hub_oe_n),
        .hub_addr(hub_addr), .hub_rgb0(hub_rgb0), .hub_rgb1(hub_rgb1),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_row(pix_row), .pix_col(pix_col),
        .pix_rgb(pix_rgb), .line_done(line_done), .oe_active(oe_active),
        .len_err(len_err), .ovf_err(ovf_err)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    int          n_acc = 0, n_valid = 0, n_done = 0;
    logic [31:0] sb_q [$];
    logic [2:0]  sh0 [80];
    logic [2:0]  sh1 [80];
    logic        rand_ready = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_word  = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack_word(input logic [4:0] row, input logic [5:0] col,
                                              input logic [2:0] rgb);
        return {18'd0, row, col, rgb};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Shift n pixels; each pixel's data is set while hub_clk is low and held through high
    task automatic hub_shift(input int n);
        for (int k = 0; k < n; k++) begin
            hub_rgb0 = sh0[k];
            hub_rgb1 = sh1[k];
            cyc(4);
            hub_clk = 1'b1;
            cyc(4);
            hub_clk = 1'b0;
        end
    endtask

    task automatic hub_latch(input logic [3:0] addr);
        hub_addr = addr;
        cyc(4);
        hub_lat = 1'b1;
        cyc(4);
        hub_lat = 1'b0;
        cyc(4);
    endtask

    // Expected words for a committed line: shift index k lands on column 63-k
    task automatic push_line(input logic [3:0] addr);
        for (int c = 0; c < c_cols; c++)
            sb_q.push_back(pack_word({1'b0, addr}, 6'(c), sh0[c_cols-1-c]));
        for (int c = 0; c < c_cols; c++)
            sb_q.push_back(pack_word({1'b1, addr}, 6'(c), sh1[c_cols-1-c]));
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((sb_q.size() != 0 || pix_valid) && n < 3000) begin
            cyc(1);
            n++;
        end
        check_val({tag, "_left"}, sb_q.size(), 0);
        check_val({tag, "_valid_end"}, {31'd0, pix_valid}, 0);
    endtask

    task automatic fill(input logic [2:0] v0, input logic [2:0] v1);
        for (int k = 0; k < 80; k++) begin
            sh0[k] = v0;
            sh1[k] = v1;
        end
    endtask

    // Scoreboard monitor and hold-under-stall checker, sampled mid-cycle
    always @(negedge clk) begin
        logic [31:0] cur, exp;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            cur = pack_word(pix_row, pix_col, pix_rgb);
            if (prev_stall)
                check_val("hold", {31'd0, pix_valid} << 20 | cur, (32'd1 << 20) | prev_word);
            if (pix_valid) n_valid++;
            if (line_done) n_done++;
            if (pix_valid && pix_ready) begin
                exp = (sb_q.size() != 0) ? sb_q.pop_front() : c_none;
                check_val("word", cur, exp);
                n_acc++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_word  = cur;
        end
    end

    // Pseudo-random backpressure
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            pix_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int b_acc, b_done, b_valid, n;

        // ---- reset state ----
        cyc(3);
        check_val("rst_valid", {31'd0, pix_valid}, 0);
        check_val("rst_oe", {31'd0, oe_active}, 0);
        check_val("rst_word", pack_word(pix_row, pix_col, pix_rgb), 0);
        check_val("rst_errs", {30'd0, len_err, ovf_err}, 0);
        rst = 1'b0;
        cyc(5);
        check_val("oe_on", {31'd0, oe_active}, 1);
        hub_oe_n = 1'b1;
        cyc(5);
        check_val("oe_off", {31'd0, oe_active}, 0);
        pix_ready = 1'b1;

        // ---- clean red pixel ----
        fill(3'b000, 3'b000);
        sh0[63] = 3'b001;
        b_done = n_done; b_acc = n_acc;
        push_line(4'd0);
        hub_shift(64);
        hub_latch(4'd0);
        wait_drain("red");
        check_val("red_acc", n_acc - b_acc, 128);
        check_val("red_done", n_done - b_done, 1);
        check_val("red_errs", {30'd0, len_err, ovf_err}, 0);

        // ---- address and halves ----
        fill(3'b000, 3'b100);
        b_done = n_done;
        push_line(4'd5);
        hub_shift(64);
        hub_latch(4'd5);
        wait_drain("halves");
        check_val("halves_done", n_done - b_done, 1);

        // ---- backpressure ----
        fill(3'b000, 3'b000);
        sh0[63] = 3'b001;
        b_acc = n_acc;
        rand_ready = 1'b1;
        push_line(4'd0);
        hub_shift(64);
        hub_latch(4'd0);
        wait_drain("bp");
        rand_ready = 1'b0;
        cyc(2);
        pix_ready = 1'b1;
        check_val("bp_acc", n_acc - b_acc, 128);

        // ---- length errors ----
        fill(3'b010, 3'b001);
        b_valid = n_valid;
        hub_shift(63);
        hub_latch(4'd2);
        cyc(10);
        check_val("short_len_err", {31'd0, len_err}, 1);
        check_val("short_no_out", n_valid - b_valid, 0);
        hub_shift(65);
        hub_latch(4'd2);
        cyc(10);
        check_val("long_len_err", {31'd0, len_err}, 1);
        check_val("long_no_out", n_valid - b_valid, 0);
        for (int k = 0; k < 80; k++) sh0[k] = 3'(k);
        push_line(4'd7);
        hub_shift(64);
        hub_latch(4'd7);
        wait_drain("after_len");

        // ---- overflow ----
        fill(3'b000, 3'b010);
        sh0[0] = 3'b111;
        b_done = n_done;
        pix_ready = 1'b0;
        push_line(4'd1);
        hub_shift(64);
        hub_latch(4'd1);
        check_val("ovf_stalled", {31'd0, pix_valid}, 1);
        fill(3'b101, 3'b011);
        hub_shift(64);
        hub_latch(4'd2);
        cyc(4);
        check_val("ovf_err", {31'd0, ovf_err}, 1);
        pix_ready = 1'b1;
        wait_drain("ovf");
        cyc(20);
        check_val("ovf_done", n_done - b_done, 1);
        check_val("ovf_no_second", {31'd0, pix_valid}, 0);

        // ---- reset mid-drain ----
        fill(3'b110, 3'b001);
        b_acc = n_acc;
        push_line(4'd9);
        hub_shift(64);
        hub_latch(4'd9);
        n = 0;
        while ((n_acc - b_acc) < 40 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_val("rst40_reached", n_acc - b_acc, 40);
        rst = 1'b1;
        pix_ready = 1'b0;
        sb_q.delete();
        cyc(1);
        check_val("mid_rst_valid", {31'd0, pix_valid}, 0);
        check_val("mid_rst_errs", {30'd0, len_err, ovf_err}, 0);
        check_val("mid_rst_word", pack_word(pix_row, pix_col, pix_rgb), 0);
        rst = 1'b0;
        pix_ready = 1'b1;
        cyc(3);
        fill(3'b011, 3'b100);
        sh0[10] = 3'b001;
        push_line(4'd3);
        hub_shift(64);
        hub_latch(4'd3);
        wait_drain("post_rst");
        check_val("post_rst_errs", {30'd0, len_err, ovf_err}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_hub75_rx
`default_nettype wire
